// File: rtl/fsmc_bus_frontend.sv
// ---------------------------------------------------------------------------
// fsmc_bus_frontend
//
// Front end of the FSMC slave buffer. Brings the asynchronous MCU FSMC pins
// into the clk domain, filters short noe/nwe pulses, flags protocol errors and
// hands the downstream buffer clean single-cycle write/read strobes. Read data
// returned by the buffer is registered onto the pad output.
//
// Optional feature macro: FSMC_NE3_EN
//   defined   : nce3 decoded as a second bank (region=1), both selects low
//               during a pulse is an error.
//   undefined : nce3 ignored, region always 0.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   noe, nwe         FSMC output/write enable (active-low, async)
//   nce2, nce3       FSMC bank chip selects (active-low, async)
//   addr, data_in    FSMC address and pad input data (async)
//   data_out/data_oe pad output value / enable (enable is combinational)
//   wr_stb/addr/data one-cycle write strobe with captured address and data
//   rd_stb/rd_addr   one-cycle read request with address
//   rd_data          downstream read data, sampled the edge after rd_stb
//   region           bank of the most recent strobe (0=nce2, 1=nce3)
//   err_cnt          saturating protocol/glitch error counter
//
// Handshake: wr_stb and rd_stb are fire-and-forget pulses; the downstream
// buffer has no ready and must accept every strobe. rd_data must be valid
// while rd_stb is high; it is captured on the following edge.
//
// FSM state is held in the internal signal 'state' for binding checkers.
// ---------------------------------------------------------------------------
module fsmc_bus_frontend #(
  parameter int DW          = 16,
  parameter int AW          = 2,
  parameter int SYNC_STAGES = 3,
  parameter int MIN_PULSE   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          noe,
  input  logic          nwe,
  input  logic          nce2,
  input  logic          nce3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_stb,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          region,
  output logic [7:0]    err_cnt
);

  // -------------------------------------------------------------------------
  // Synchronisers: stage 0 samples the pin, stage SYNC_STAGES-1 is used.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]         noe_sync;
  logic [SYNC_STAGES-1:0]         nwe_sync;
  logic [SYNC_STAGES-1:0]         nce2_sync;
  logic [SYNC_STAGES-1:0][AW-1:0] addr_sync;
  logic [SYNC_STAGES-1:0][DW-1:0] data_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      noe_sync  <= '1;
      nwe_sync  <= '1;
      nce2_sync <= '1;
      addr_sync <= '0;
      data_sync <= '0;
    end else begin
      noe_sync  <= {noe_sync[SYNC_STAGES-2:0], noe};
      nwe_sync  <= {nwe_sync[SYNC_STAGES-2:0], nwe};
      nce2_sync <= {nce2_sync[SYNC_STAGES-2:0], nce2};
      addr_sync <= {addr_sync[SYNC_STAGES-2:0], addr};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
    end
  end

  logic          noe_s;
  logic          nwe_s;
  logic          nce2_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_s;
  logic          sel_s;   // some bank selected
  logic          bank_s;  // 1 when the nce3 bank is the one selected
  logic          conf_s;  // both banks selected at once (protocol error)

  assign noe_s  = noe_sync[SYNC_STAGES-1];
  assign nwe_s  = nwe_sync[SYNC_STAGES-1];
  assign nce2_s = nce2_sync[SYNC_STAGES-1];
  assign addr_s = addr_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

`ifdef FSMC_NE3_EN
  logic [SYNC_STAGES-1:0] nce3_sync;
  logic                   nce3_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nce3_sync <= '1;
    end else begin
      nce3_sync <= {nce3_sync[SYNC_STAGES-2:0], nce3};
    end
  end

  assign nce3_s  = nce3_sync[SYNC_STAGES-1];
  assign sel_s   = ~nce2_s | ~nce3_s;
  assign bank_s  = ~nce3_s;
  assign conf_s  = ~nce2_s & ~nce3_s;
  // Pad enable follows the raw pins so the bus turns around without delay.
  assign data_oe = rst_n & ~noe & (~nce2 | ~nce3);
`else
  logic unused_nce3;

  assign unused_nce3 = nce3;
  assign sel_s       = ~nce2_s;
  assign bank_s      = 1'b0;
  assign conf_s      = 1'b0;
  assign data_oe     = rst_n & ~noe & ~nce2;
`endif

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic [7:0] err_nxt;
  logic [2:0] settle_cnt;
  logic       settled;

  assign cnt_inc = (cnt == 4'd15) ? cnt : cnt + 4'd1;
  assign err_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // The synchronisers are preset to "idle" in reset, so for SYNC_STAGES
  // cycles after release their outputs do not yet reflect the pins. Holding
  // WAIT_IDLE until the pipeline has refilled keeps a pulse that was already
  // in progress at reset release from looking like a fresh one.
  assign settled = (settle_cnt == 3'(SYNC_STAGES));

  // Write capture registers, refreshed every synced-low cycle of nwe so the
  // strobe carries the values present at the end of the pulse.
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          cap_sel;
  logic          cap_bank;
  logic          cap_conf;

  // -------------------------------------------------------------------------
  // Protocol FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    WR        = 3'd2,
    RD        = 3'd3,
    RD_HOLD   = 3'd4
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_IDLE;
      cnt        <= 4'd0;
      settle_cnt <= 3'd0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      data_out   <= '0;
      region     <= 1'b0;
      err_cnt    <= 8'd0;
      cap_addr   <= '0;
      cap_data   <= '0;
      cap_sel    <= 1'b0;
      cap_bank   <= 1'b0;
      cap_conf   <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction.
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;

      if (!settled) begin
        settle_cnt <= settle_cnt + 3'd1;
      end

      case (state)
        WAIT_IDLE: begin
          if (settled && noe_s && nwe_s) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!noe_s && !nwe_s) begin
            err_cnt <= err_nxt;
            state   <= WAIT_IDLE;
          end else if (!nwe_s) begin
            state    <= WR;
            cnt      <= 4'd1;
            cap_addr <= addr_s;
            cap_data <= data_s;
            cap_sel  <= sel_s;
            cap_bank <= bank_s;
            cap_conf <= conf_s;
          end else if (!noe_s) begin
            state <= RD;
            cnt   <= 4'd1;
          end
        end

        WR: begin
          if (!noe_s) begin
            err_cnt <= err_nxt;
            state   <= WAIT_IDLE;
          end else if (!nwe_s) begin
            cnt      <= cnt_inc;
            cap_addr <= addr_s;
            cap_data <= data_s;
            cap_sel  <= sel_s;
            cap_bank <= bank_s;
            cap_conf <= conf_s;
          end else begin
            // nwe released: decide on the whole pulse.
            state <= IDLE;
            if (cnt < 4'(MIN_PULSE)) begin
              err_cnt <= err_nxt;
            end else if (cap_conf) begin
              err_cnt <= err_nxt;
            end else if (cap_sel) begin
              wr_stb  <= 1'b1;
              wr_addr <= cap_addr;
              wr_data <= cap_data;
              region  <= cap_bank;
            end
          end
        end

        RD: begin
          if (!nwe_s) begin
            err_cnt <= err_nxt;
            state   <= WAIT_IDLE;
          end else if (noe_s) begin
            // Released before the pulse qualified.
            state <= IDLE;
            if (cnt < 4'(MIN_PULSE)) begin
              err_cnt <= err_nxt;
            end
          end else begin
            cnt <= cnt_inc;
            // Request the read as soon as the pulse qualifies so the data
            // has the rest of the noe low time to reach the pads.
            if (cnt_inc >= 4'(MIN_PULSE)) begin
              state <= RD_HOLD;
              if (conf_s) begin
                err_cnt <= err_nxt;
              end else if (sel_s) begin
                rd_stb  <= 1'b1;
                rd_addr <= addr_s;
                region  <= bank_s;
              end
            end
          end
        end

        RD_HOLD: begin
          // rd_stb is still high on the first cycle here, which is exactly
          // when the downstream read data is presented.
          if (rd_stb) begin
            data_out <= rd_data;
          end
          if (!nwe_s) begin
            err_cnt <= err_nxt;
            state   <= WAIT_IDLE;
          end else if (noe_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsmc_bus_frontend.sv
`timescale 1ns/1ps
module tb_fsmc_bus_frontend;

  localparam int DW          = 16;
  localparam int AW          = 2;
  localparam int SYNC_STAGES = 3;
  localparam int MIN_PULSE   = 2;
`ifdef FSMC_NE3_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_BOTH = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          noe = 1'b1;
  logic          nwe = 1'b1;
  logic          nce2 = 1'b1;
  logic          nce3 = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_stb;
  logic [AW-1:0] rd_addr;
  logic          region;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  fsmc_bus_frontend #(
    .DW(DW), .AW(AW), .SYNC_STAGES(SYNC_STAGES), .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .noe(noe), .nwe(nwe), .nce2(nce2), .nce3(nce3),
    .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data),
    .region(region), .err_cnt(err_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+DW:0] exp_wr_q[$];
  logic [AW+DW:0] wr_obs_q[$];
  logic [AW:0]    exp_rd_q[$];
  logic [AW:0]    rd_obs_q[$];
  int             exp_err  = 0;
  logic [DW-1:0]  exp_dout = '0;
  logic [DW-1:0]  rd_value = '0;
  logic           prev_stb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Monitor + read responder: records strobes, supplies rd_data on rd_stb.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_stb || rd_stb) begin
        n_checks++;
        if ((wr_stb && rd_stb) || prev_stb) begin
          n_fail++;
          $display("FAIL strobe_rule: wr_stb=%b rd_stb=%b prev=%b, expected one isolated strobe",
                   wr_stb, rd_stb, prev_stb);
        end
      end
      prev_stb = wr_stb || rd_stb;
      if (wr_stb) wr_obs_q.push_back({region, wr_addr, wr_data});
      if (rd_stb) begin
        rd_obs_q.push_back({region, rd_addr});
        rd_data = rd_value;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_txn(input int kind, input logic n2, input logic n3,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int low, input logic [DW-1:0] rdv);
    @(negedge clk);
    rd_value = rdv;
    rd_data  = ~rdv;
    nce2 = n2; nce3 = n3; addr = a; data_in = d;
    @(negedge clk);
    if (kind != K_RD) nwe = 1'b0;
    if (kind != K_WR) noe = 1'b0;
    #1;
    check("data_oe_low", 32'(data_oe), 32'((kind != K_WR) && (!n2 || (FEAT && !n3))));
    repeat (low) @(negedge clk);
    noe = 1'b1; nwe = 1'b1;
    #1;
    check("data_oe_high", 32'(data_oe), 32'd0);
    repeat (SYNC_STAGES + 6) @(negedge clk);
    nce2 = 1'b1; nce3 = 1'b1;
  endtask

  // Transaction-level reference: what the bus cycle should produce.
  task automatic model_txn(input int kind, input logic n2, input logic n3,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int low, input logic [DW-1:0] rdv);
    bit s2, s3, sel, conf;
    s2   = !n2;
    s3   = FEAT && !n3;
    sel  = s2 || s3;
    conf = s2 && s3;
    if (kind == K_BOTH || low < MIN_PULSE || conf) begin
      exp_err = sat_inc(exp_err);
    end else if (sel) begin
      if (kind == K_WR) exp_wr_q.push_back({s3, a, d});
      else begin
        exp_rd_q.push_back({s3, a});
        exp_dout = rdv;
      end
    end
  endtask

  task automatic score(input string tag);
    check({tag, "_wr_count"}, wr_obs_q.size(), exp_wr_q.size());
    while (wr_obs_q.size() > 0 && exp_wr_q.size() > 0)
      check({tag, "_wr_rec"}, 32'(wr_obs_q.pop_front()), 32'(exp_wr_q.pop_front()));
    check({tag, "_rd_count"}, rd_obs_q.size(), exp_rd_q.size());
    while (rd_obs_q.size() > 0 && exp_rd_q.size() > 0)
      check({tag, "_rd_rec"}, 32'(rd_obs_q.pop_front()), 32'(exp_rd_q.pop_front()));
    wr_obs_q.delete(); exp_wr_q.delete();
    rd_obs_q.delete(); exp_rd_q.delete();
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_dout));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            kind;
    logic          n2;
    logic          n3;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            low;
    logic [DW-1:0] rdv;
    int            exp_wr;
    int            exp_rd;
    int            exp_err;
    logic          exp_region;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int kind, input logic n2, input logic n3,
                              input logic [AW-1:0] a, input logic [DW-1:0] d, input int low,
                              input logic [DW-1:0] rdv, input int ew, input int er,
                              input int ee, input logic eg);
    vec_t v;
    v.kind = kind; v.n2 = n2; v.n3 = n3; v.a = a; v.d = d; v.low = low; v.rdv = rdv;
    v.exp_wr = ew; v.exp_rd = er; v.exp_err = ee; v.exp_region = eg;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // Reset with noe asserted on a selected bank: pad must stay off.
    rst_n = 1'b0; noe = 1'b0; nce2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_rd_stb", 32'(rd_stb), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_region", 32'(region), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);

    // Release reset in the middle of a write pulse: it must be ignored.
    noe = 1'b1; nce2 = 1'b0; nwe = 1'b0; addr = 2'd3; data_in = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    nwe = 1'b1;
    repeat (10) @(negedge clk);
    nce2 = 1'b1;
    score("held_pulse");

    // Normal write, exact strobe latency after the nwe rise.
    @(negedge clk);
    nce2 = 1'b0; addr = 2'd0; data_in = 16'h1234;
    @(negedge clk);
    nwe = 1'b0;
    repeat (4) @(negedge clk);
    nwe = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("wr_latency", 32'(wr_stb), 32'(i == SYNC_STAGES + 1));
    end
    repeat (4) @(negedge clk);
    nce2 = 1'b1;
    exp_wr_q.push_back({1'b0, 2'd0, 16'h1234});
    score("first_write");

    // Read with noe low 6 clk: rd_stb on edge 5, data_out on edge 6.
    @(negedge clk);
    nce2 = 1'b0; addr = 2'd0; rd_value = 16'hBEEF; rd_data = 16'h0000;
    @(negedge clk);
    noe = 1'b0;
    #1;
    check("rd_data_oe_on", 32'(data_oe), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("rd_latency", 32'(rd_stb), 32'(i == SYNC_STAGES + MIN_PULSE));
      if (i == 6) check("rd_data_out_edge6", 32'(data_out), 32'hBEEF);
    end
    noe = 1'b1;
    #1;
    check("rd_data_oe_off", 32'(data_oe), 32'd0);
    repeat (9) @(negedge clk);
    nce2 = 1'b1;
    exp_rd_q.push_back({1'b0, 2'd0});
    exp_dout = 16'hBEEF;
    score("first_read");

    // Table: kind n2 n3 addr data low rdv | wr rd err region
    vecs.push_back(mk(K_WR,   0, 1, 2'd1, 16'hCAFE, 4,  16'h0, 1, 0, 0, 0));
    vecs.push_back(mk(K_RD,   0, 1, 2'd2, 16'h0,    4,  16'h1357, 0, 1, 0, 0));
    vecs.push_back(mk(K_WR,   0, 1, 2'd3, 16'h1111, 1,  16'h0, 0, 0, 1, 0));
    vecs.push_back(mk(K_BOTH, 0, 1, 2'd0, 16'h2222, 3,  16'h0, 0, 0, 1, 0));
    vecs.push_back(mk(K_WR,   0, 1, 2'd2, 16'h4444, 3,  16'h0, 1, 0, 0, 0));
    vecs.push_back(mk(K_WR,   1, 1, 2'd1, 16'h5555, 4,  16'h0, 0, 0, 0, 0));
    vecs.push_back(mk(K_RD,   0, 1, 2'd1, 16'h0,    1,  16'h7777, 0, 0, 1, 0));
    vecs.push_back(mk(K_RD,   1, 1, 2'd3, 16'h0,    4,  16'h8888, 0, 0, 0, 0));
    vecs.push_back(mk(K_WR,   0, 1, 2'd2, 16'h6666, 2,  16'h0, 1, 0, 0, 0));
    vecs.push_back(mk(K_RD,   0, 1, 2'd3, 16'h0,    2,  16'h2468, 0, 1, 0, 0));
    vecs.push_back(mk(K_WR,   0, 1, 2'd0, 16'h7777, 20, 16'h0, 1, 0, 0, 0));
    vecs.push_back(mk(K_WR,   1, 0, 2'd3, 16'hA5A5, 4,  16'h0, int'(FEAT), 0, 0, 1));
    vecs.push_back(mk(K_WR,   0, 0, 2'd1, 16'h9999, 4,  16'h0, int'(!FEAT), 0, int'(FEAT), 0));
    vecs.push_back(mk(K_RD,   1, 0, 2'd2, 16'h0,    4,  16'h0F0F, 0, int'(FEAT), 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_txn(vecs[i].kind, vecs[i].n2, vecs[i].n3, vecs[i].a, vecs[i].d,
                vecs[i].low, vecs[i].rdv);
      if (vecs[i].exp_wr != 0) exp_wr_q.push_back({vecs[i].exp_region, vecs[i].a, vecs[i].d});
      if (vecs[i].exp_rd != 0) begin
        exp_rd_q.push_back({vecs[i].exp_region, vecs[i].a});
        exp_dout = vecs[i].rdv;
      end
      if (vecs[i].exp_err != 0) exp_err = sat_inc(exp_err);
      score($sformatf("vec%0d", i));
    end

    // Randomized bus cycles against the transaction model.
    for (int i = 0; i < 40; i++) begin
      int            kind;
      logic          n2, n3;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rdv;
      int            low;
      kind = $urandom_range(0, 2);
      n2   = ($urandom_range(0, 3) == 0);
      n3   = ($urandom_range(0, 2) != 0);
      a    = AW'($urandom_range(0, (1 << AW) - 1));
      d    = DW'($urandom);
      rdv  = DW'($urandom);
      low  = $urandom_range(1, 5);
      drive_txn(kind, n2, n3, a, d, low, rdv);
      model_txn(kind, n2, n3, a, d, low, rdv);
      score("rand");
    end

    // Drive the error counter into saturation with short glitches.
    for (int i = 0; i < 260; i++) begin
      drive_txn(K_WR, 1'b0, 1'b1, 2'd1, 16'h0101, 1, 16'h0);
      model_txn(K_WR, 1'b0, 1'b1, 2'd1, 16'h0101, 1, 16'h0);
    end
    score("err_saturate");
    check("err_cnt_is_255", 32'(err_cnt), 32'd255);

    // A clean write still works after saturation.
    drive_txn(K_WR, 1'b0, 1'b1, 2'd2, 16'h3C3C, 4, 16'h0);
    model_txn(K_WR, 1'b0, 1'b1, 2'd2, 16'h3C3C, 4, 16'h0);
    score("post_saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
